// File: rtl/bit_reverser_stream.sv
// Streaming WIDTH-bit reorderer (pass / full reverse / group swap / in-group reverse) with valid/ready
// handshake and delivered-word counter. Define BITREV_SKID_EN for a 2-entry buffer with registered D_RDY.
module bit_reverser_stream #(
  parameter int WIDTH = 8,
  parameter int GROUP = 4,
  parameter int CNT_W = 16
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic [WIDTH-1:0] D_IN,
  input  logic [1:0]       D_MODE,
  input  logic             D_VLD,
  output logic             D_RDY,
  output logic [WIDTH-1:0] D_OUT,
  output logic             O_VLD,
  input  logic             O_RDY,
  output logic [CNT_W-1:0] O_CNT
);

  localparam int NGRP = WIDTH / GROUP;

  if (WIDTH < 2 || (WIDTH % GROUP) != 0) begin : g_bad_cfg
    $error("bit_reverser_stream: WIDTH must be >= 2 and a multiple of GROUP");
  end

  typedef enum logic [1:0] {
    EMPTY     = 2'b00,
    FULL      = 2'b01,
    FULL_SKID = 2'b11
  } state_t;

  state_t           state;
  logic             accept;
  logic             deliver;
  logic [WIDTH-1:0] w_rev;
  logic [WIDTH-1:0] w_gswap;
  logic [WIDTH-1:0] w_grev;
  logic [WIDTH-1:0] d_mapped;

  for (genvar i = 0; i < WIDTH; i++) begin : g_rev
    assign w_rev[i] = D_IN[WIDTH-1-i];
  end

  for (genvar k = 0; k < NGRP; k++) begin : g_grp
    for (genvar j = 0; j < GROUP; j++) begin : g_bit
      assign w_gswap[(NGRP-1-k)*GROUP + j] = D_IN[k*GROUP + j];
      assign w_grev[k*GROUP + j]           = D_IN[k*GROUP + GROUP-1-j];
    end
  end

  always_comb begin
    d_mapped = D_IN;
    case (D_MODE)
      2'd1:    d_mapped = w_rev;
      2'd2:    d_mapped = w_gswap;
      2'd3:    d_mapped = w_grev;
      default: d_mapped = D_IN;
    endcase
  end

  assign O_VLD   = (state != EMPTY);
  assign accept  = D_VLD && D_RDY;
  assign deliver = O_VLD && O_RDY;

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      O_CNT <= '0;
    end else if (deliver) begin
      O_CNT <= O_CNT + CNT_W'(1);
    end
  end

`ifdef BITREV_SKID_EN
  logic [WIDTH-1:0] skid;
  logic             rdy_q;

  assign D_RDY = rdy_q;

  // rdy_q mirrors "skid register empty" for the state being entered, so D_RDY never sees O_RDY.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state <= EMPTY;
      D_OUT <= '0;
      skid  <= '0;
      rdy_q <= 1'b0;
    end else begin
      rdy_q <= 1'b1;
      case (state)
        EMPTY: begin
          if (accept) begin
            D_OUT <= d_mapped;
            state <= FULL;
          end
        end
        FULL: begin
          if (accept && !deliver) begin
            skid  <= d_mapped;
            state <= FULL_SKID;
            rdy_q <= 1'b0;
          end else if (accept) begin
            D_OUT <= d_mapped;
          end else if (deliver) begin
            state <= EMPTY;
          end
        end
        FULL_SKID: begin
          rdy_q <= deliver;
          if (deliver) begin
            D_OUT <= skid;
            state <= FULL;
          end
        end
        default: state <= EMPTY;
      endcase
    end
  end
`else
  assign D_RDY = RST_N && (!O_VLD || O_RDY);

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state <= EMPTY;
      D_OUT <= '0;
    end else if (accept) begin
      D_OUT <= d_mapped;
      state <= FULL;
    end else if (deliver) begin
      state <= EMPTY;
    end
  end
`endif

endmodule

// File: doc/bit_reverser_stream.md
# bit_reverser_stream

Streaming, parametrised successor to the combinational bit reverser: accepts `WIDTH`-bit words over a valid/ready handshake and applies a per-word selectable reordering (pass, full bit reverse, group-order swap, in-group bit reverse). Each word is registered and emitted one cycle later, with backpressure and an output word counter. It sits between the word-buffer logic and the panel shift-out path, where column order flips depending on panel orientation.

## Interface
- `WIDTH`, 8: data word width in bits; must be ≥ 2.
- `GROUP`, 4: group size for modes 2 and 3; `WIDTH % GROUP == 0` is required; the block fails elaboration otherwise.
- `CNT_W`, 16: width of the output word counter.
- `CLK`  in  1  sole clock; all logic updates on the rising edge.
- `RST_N`  in  1  synchronous, active-low reset, sampled on the `CLK` rising edge.
- `D_IN`  in  `WIDTH`  input word.
- `D_MODE`  in  2  reorder mode, sampled together with `D_IN`.
- `D_VLD`  in  1  input word valid.
- `D_RDY`  out  1  block can accept a word.
- `D_OUT`  out  `WIDTH`  reordered word.
- `O_VLD`  out  1  `D_OUT` valid.
- `O_RDY`  in  1  downstream accepts `D_OUT`.
- `O_CNT`  out  `CNT_W`  count of words delivered (output handshakes), modulo 2^`CNT_W`.

## Operation
- Input handshake: a word is accepted on an edge where `D_VLD && D_RDY`.
- Output handshake: a word is delivered on an edge where `O_VLD && O_RDY`.
- `D_IN` and `D_MODE` must hold while `D_VLD && !D_RDY`. `D_OUT` holds while `O_VLD && !O_RDY`.
- The reorder function is combinational on the accepted word; the result is captured into the output register.
  - Mode 0: pass-through.
  - Mode 1: full reverse; `out[i] = in[WIDTH-1-i]`.
  - Mode 2: group-order swap; group k moves to group `WIDTH/GROUP-1-k`, and bits inside each group keep their order.
  - Mode 3: in-group bit reverse; each `GROUP`-bit field is reversed in place, and group positions are unchanged.
  - When `GROUP == WIDTH`, mode 2 equals mode 0 and mode 3 equals mode 1.
- Mode is per word. Changing `D_MODE` between words needs no drain.
- `O_CNT` increments by 1 on each output handshake and wraps from 2^`CNT_W`-1 to 0. Accepted-but-undelivered words are not counted.
- Word order is strictly FIFO. No word is dropped or duplicated under any `O_RDY` pattern.
- Reset, including mid-operation: every buffered word is discarded and the block returns to the reset state. Words in flight are lost; this is by design.

## Timing
- Reset values, held while `RST_N` is low: `O_VLD=0`, `D_OUT=0`, `O_CNT=0`, `D_RDY=0`.
  - `D_RDY` rises on the first edge with `RST_N` high.
- Latency: a word accepted at edge n appears with `O_VLD=1` after edge n. One cycle, no bubbles.
- Throughput: one word per cycle while `O_RDY` is held high.
- Simultaneous input accept and output deliver on a full output register: the register loads the new word, `O_VLD` stays 1, and `O_CNT` increments.
- Output register states (without skid): EMPTY (`O_VLD=0`) and FULL (`O_VLD=1`).
  - EMPTY → FULL on accept.
  - FULL → EMPTY on deliver with no accept.
  - FULL → FULL on deliver with accept, or on stall.

## Configuration
- `BITREV_SKID_EN` defined: 2-entry buffer (output register plus skid register) and fully registered `D_RDY`.
  - `D_RDY` = skid register empty; it has no combinational path from `O_RDY`.
  - A word accepted while the output register is FULL and `O_RDY=0` goes to the skid register, and `D_RDY` falls on the next edge.
  - On the next output handshake, skid moves to the output register and `D_RDY` rises on the following edge.
  - At most two words are buffered.
- `BITREV_SKID_EN` undefined: single output register.
  - `D_RDY = RST_N && (!O_VLD || O_RDY)`, combinational.
  - At most one word is buffered.
- Reorder function, latency, throughput with `O_RDY` high, and `O_CNT` are identical in both builds.

## Test plan
- Reset: hold `RST_N=0` for 3 edges with `D_VLD=1` → `O_VLD=0`, `D_OUT=0`, `O_CNT=0`, `D_RDY=0`; `D_RDY=1` after the first edge with `RST_N` high.
- Modes, `WIDTH=8`, `GROUP=4`, `D_IN=8'h16` with `O_RDY=1`: mode 0 → `8'h16`, mode 1 → `8'h68`, mode 2 → `8'h61`, mode 3 → `8'h86`, each one cycle after acceptance.
- Streaming: 16 back-to-back words in mode 1 with `O_RDY=1` → 16 consecutive `O_VLD` cycles in order; `O_CNT` ends at 16.
- Backpressure: `O_RDY=0` for 5 cycles mid-stream.
  - With skid: exactly 2 words accepted, then `D_RDY=0`.
  - Without skid: exactly 1 word accepted.
  - After `O_RDY` rises, the sequence resumes with no loss or duplication.
- Reset mid-stream: assert `RST_N=0` with `O_VLD=1` and skid full → next edge `O_VLD=0` and `O_CNT=0`; the buffered words never appear.
- Wrap: `CNT_W=4` with 17 deliveries → `O_CNT` reads 15 after delivery 15, 0 after delivery 16, and 1 after delivery 17.
